// File: rtl/softmax_max_finder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// softmax_max_finder_if : logit stream in, max result out
// Revision 1.0
// ----------------------------------------------------------------------------
interface softmax_max_finder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 4
);
    logic                  start;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] max_out;
    logic [CNT_WIDTH-1:0]  max_idx;
    logic                  max_write;
    logic                  busy;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, max_out, max_idx, max_write, busy
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, max_out, max_idx, max_write, busy
    );
endinterface
`default_nettype wire

// File: rtl/softmax_max_finder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// softmax_max_finder : streaming signed max/argmax search over one vector
// Revision 1.0
// ----------------------------------------------------------------------------
module softmax_max_finder #(
    parameter int DATA_WIDTH = 16,
    parameter int VEC_LEN    = 10,
    parameter int CNT_WIDTH  = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    softmax_max_finder_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(VEC_LEN - 1);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] run_max_q, run_max_d;
    logic [CNT_WIDTH-1:0]  run_idx_q, run_idx_d;
    logic [DATA_WIDTH-1:0] max_out_q, max_out_d;
    logic [CNT_WIDTH-1:0]  max_idx_q, max_idx_d;
    logic                  accept;
    logic                  take;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        run_max_d = run_max_q;
        run_idx_d = run_idx_q;
        max_out_d = max_out_q;
        max_idx_d = max_idx_q;
        accept    = 1'b0;
        take      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_SCAN;
                    cnt_d     = '0;
                    run_max_d = '0;
                    run_idx_d = '0;
                end
            end
            ST_SCAN: begin
                accept = bus.in_valid;
                // Strict greater-than keeps the earliest index on ties.
                take   = accept && ((cnt_q == '0) ||
                                    ($signed(bus.in_data) > $signed(run_max_q)));
                if (take) begin
                    run_max_d = bus.in_data;
                    run_idx_d = cnt_q;
                end
                if (accept) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d   = ST_DONE;
                        max_out_d = run_max_d;
                        max_idx_d = run_idx_d;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            run_max_q <= '0;
            run_idx_q <= '0;
            max_out_q <= '0;
            max_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            run_max_q <= run_max_d;
            run_idx_q <= run_idx_d;
            max_out_q <= max_out_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_SCAN);
    assign bus.max_write = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.max_out   = max_out_q;
    assign bus.max_idx   = max_idx_q;

endmodule
`default_nettype wire
